// File: rtl/poker_betting_round_scheduler_pkg.sv
// poker_betting_round_scheduler_pkg: shared action codes, money width and FSM encoding
package poker_betting_round_scheduler_pkg;
   localparam int MONEY_W = 8;
   typedef logic [MONEY_W-1:0] money_t;
   localparam logic [2:0] A_NONE   = 3'b000;
   localparam logic [2:0] A_FOLD   = 3'b001;
   localparam logic [2:0] A_CHECK  = 3'b010;
   localparam logic [2:0] A_ALL_IN = 3'b011;
   localparam logic [2:0] A_CALL   = 3'b100;
   localparam logic [2:0] A_BET    = 3'b110;
   localparam logic [2:0] A_RAISE  = 3'b111;
   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT_V, S_CHECK, S_ACK, S_UPDATE, S_DONE} state_t;
endpackage

// File: rtl/poker_betting_round_scheduler_if.sv
// poker_betting_round_scheduler_if: dealer <-> player move handshake and table view
interface poker_betting_round_scheduler_if;
   import poker_betting_round_scheduler_pkg::*;
   logic       output_valid;
   logic [2:0] action;
   money_t     make_bet;
   logic       request;
   logic       ack;
   logic       invalid;
   money_t     money_left;
   logic [2:0] opp_action;
   money_t     opp_bet;
   modport master (input output_valid, action, make_bet,
                   output request, ack, invalid, money_left, opp_action, opp_bet);
   modport slave (output output_valid, action, make_bet,
                  input request, ack, invalid, money_left, opp_action, opp_bet);
endinterface

// File: rtl/poker_betting_round_scheduler_move_checker.sv
// poker_move_checker: legality and chip cost of one move given stack and amount owed
module poker_move_checker
   import poker_betting_round_scheduler_pkg::*;
(
   input  logic [2:0] action,
   input  money_t     bet,
   input  money_t     stack,
   input  money_t     to_call,
   output logic       legal,
   output money_t     pay
);
   // decode the move; pay is only meaningful when legal
   always_comb begin
      legal = 1'b0;
      pay = '0;
      case (action)
         A_FOLD: legal = 1'b1;
         A_CHECK: legal = to_call == '0;
         A_CALL: begin
            legal = to_call != '0;
            pay = to_call < stack ? to_call : stack;
         end
         A_BET: begin
            legal = to_call == '0 && bet != '0 && bet <= stack;
            pay = bet;
         end
         A_RAISE: begin
            legal = to_call != '0 && bet > to_call && bet <= stack;
            pay = bet;
         end
         A_ALL_IN: begin
            legal = stack != '0;
            pay = stack;
         end
         default: legal = 1'b0;
      endcase
   end
endmodule

// File: rtl/poker_betting_round_scheduler.sv
// poker_betting_round_scheduler: grants turns, checks moves, keeps stacks/pot, reports round end
module poker_betting_round_scheduler
   import poker_betting_round_scheduler_pkg::*;
#(
   parameter int TIMEOUT_CYC = 1024,
   parameter int MAX_INVALID = 3
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   round_start,
   input  logic   first_player,
   input  logic   new_hand,
   input  logic   stack_load,
   input  money_t stack_init,
   poker_betting_round_scheduler_if.master p0,
   poker_betting_round_scheduler_if.master p1,
   output money_t pot_size,
   output logic   round_done,
   output logic   hand_over,
   output logic   winner
);
   localparam int TW = $clog2(TIMEOUT_CYC) + 1;
   localparam int IW = $clog2(MAX_INVALID) + 1;
   state_t state_q, state_d;
   logic cur_q, cur_d, fold_q, fold_d, winner_q, winner_d;
   logic [2:0] act_q, act_d, m_act;
   money_t bet_q, bet_d, pot_q, pot_d, pay, to_call, m_bet;
   logic [TW-1:0] timer_q, timer_d;
   logic [IW-1:0] inv_q, inv_d;
   logic [1:0][MONEY_W-1:0] stack_q, stack_d, contrib_q, contrib_d, last_bet_q, last_bet_d;
   logic [1:0][2:0] last_act_q, last_act_d;
   logic [1:0] allin_q, allin_d, acted_q, acted_d;
   logic legal, m_valid, settle;
   logic [MONEY_W:0] pot_sum;
   assign m_valid = cur_q ? p1.output_valid : p0.output_valid;
   assign m_act = cur_q ? p1.action : p0.action;
   assign m_bet = cur_q ? p1.make_bet : p0.make_bet;
   assign to_call = contrib_q[~cur_q] > contrib_q[cur_q] ? contrib_q[~cur_q] - contrib_q[cur_q] : '0;
   poker_move_checker u_chk (
      .action (act_q),
      .bet    (bet_q),
      .stack  (stack_q[cur_q]),
      .to_call(to_call),
      .legal  (legal),
      .pay    (pay)
   );
   // turn sequencing, move capture and table bookkeeping
   always_comb begin
      state_d = state_q;
      cur_d = cur_q;
      act_d = act_q;
      bet_d = bet_q;
      timer_d = timer_q;
      inv_d = inv_q;
      stack_d = stack_q;
      contrib_d = contrib_q;
      pot_d = pot_q;
      last_act_d = last_act_q;
      last_bet_d = last_bet_q;
      allin_d = allin_q;
      acted_d = acted_q;
      fold_d = fold_q;
      winner_d = winner_q;
      settle = 1'b0;
      pot_sum = {1'b0, pot_q} + {1'b0, pay};
      case (state_q)
         S_IDLE: begin
            if (stack_load) stack_d = {stack_init, stack_init};
            if (round_start) begin
               contrib_d = '0;
               acted_d = '0;
               inv_d = '0;
               cur_d = first_player;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            timer_d = '0;
            act_d = A_CHECK;
            bet_d = '0;
            state_d = allin_q[cur_q] ? S_UPDATE : S_WAIT_V;
         end
         S_WAIT_V: begin
            if (m_valid) begin
               act_d = m_act;
               bet_d = m_bet;
               state_d = S_CHECK;
            end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
               act_d = A_FOLD;
               state_d = S_UPDATE;
            end else begin
               timer_d = &timer_q ? timer_q : timer_q + 1'b1;
            end
         end
         S_CHECK: begin
            if (legal) begin
               state_d = S_ACK;
            end else begin
               inv_d = inv_q + 1'b1;
               act_d = A_FOLD;
               state_d = int'(inv_q) + 1 >= MAX_INVALID ? S_UPDATE : S_REQ;
            end
         end
         S_ACK: state_d = m_valid ? S_ACK : S_UPDATE;
         S_UPDATE: begin
            stack_d[cur_q] = stack_q[cur_q] - pay;
            contrib_d[cur_q] = contrib_q[cur_q] + pay;
            pot_d = pot_sum[MONEY_W] ? '1 : pot_sum[MONEY_W-1:0];
            last_act_d[cur_q] = act_q;
            last_bet_d[cur_q] = pay;
            acted_d[cur_q] = 1'b1;
            allin_d[cur_q] = allin_q[cur_q] | (act_q == A_ALL_IN) | (pay != '0 && pay == stack_q[cur_q]);
            settle = (act_q == A_FOLD) | (&acted_d & (contrib_d[0] == contrib_d[1])) | (&allin_d)
                   | (allin_d[0] & acted_d[1] & (contrib_d[1] >= contrib_d[0]))
                   | (allin_d[1] & acted_d[0] & (contrib_d[0] >= contrib_d[1]));
            fold_d = act_q == A_FOLD;
            winner_d = ~cur_q;
            inv_d = '0;
            cur_d = ~cur_q;
            state_d = settle ? S_DONE : S_REQ;
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (new_hand) begin
         state_d = S_IDLE;
         contrib_d = '0;
         acted_d = '0;
         allin_d = '0;
         fold_d = 1'b0;
      end
   end
   // state register with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cur_q <= 1'b0;
         act_q <= A_NONE;
         bet_q <= '0;
         timer_q <= '0;
         inv_q <= '0;
         stack_q <= '0;
         contrib_q <= '0;
         pot_q <= '0;
         last_act_q <= {A_NONE, A_NONE};
         last_bet_q <= '0;
         allin_q <= '0;
         acted_q <= '0;
         fold_q <= 1'b0;
         winner_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cur_q <= cur_d;
         act_q <= act_d;
         bet_q <= bet_d;
         timer_q <= timer_d;
         inv_q <= inv_d;
         stack_q <= stack_d;
         contrib_q <= contrib_d;
         pot_q <= pot_d;
         last_act_q <= last_act_d;
         last_bet_q <= last_bet_d;
         allin_q <= allin_d;
         acted_q <= acted_d;
         fold_q <= fold_d;
         winner_q <= winner_d;
      end
   end
   assign p0.request = ~cur_q & (state_q == S_WAIT_V | (state_q == S_REQ & ~allin_q[0]));
   assign p1.request = cur_q & (state_q == S_WAIT_V | (state_q == S_REQ & ~allin_q[1]));
   assign p0.ack = ~cur_q & (state_q == S_ACK);
   assign p1.ack = cur_q & (state_q == S_ACK);
   assign p0.invalid = ~cur_q & (state_q == S_CHECK) & ~legal;
   assign p1.invalid = cur_q & (state_q == S_CHECK) & ~legal;
   assign p0.money_left = stack_q[0];
   assign p1.money_left = stack_q[1];
   assign p0.opp_action = last_act_q[1];
   assign p1.opp_action = last_act_q[0];
   assign p0.opp_bet = last_bet_q[1];
   assign p1.opp_bet = last_bet_q[0];
   assign pot_size = pot_q;
   assign round_done = state_q == S_DONE;
   assign hand_over = (state_q == S_DONE) & fold_q;
   assign winner = (state_q == S_DONE) & fold_q & winner_q;
endmodule

// File: tb/tb_poker_betting_round_scheduler.sv
// tb_poker_betting_round_scheduler: scenario tasks with a round-result scoreboard
module tb_poker_betting_round_scheduler;
   import poker_betting_round_scheduler_pkg::*;
   localparam int TO = 1024;
   typedef struct packed {logic ho; logic w; money_t pot; money_t s0; money_t s1;} exp_t;
   logic clk = 1'b0, rst_n = 1'b0, round_start = 1'b0, first_player = 1'b0, new_hand = 1'b0, stack_load = 1'b0;
   money_t stack_init = '0, pot_size;
   logic round_done, hand_over, winner;
   int errors = 0, checks = 0, inv1 = 0, req1 = 0;
   exp_t sb[$];
   poker_betting_round_scheduler_if i0 ();
   poker_betting_round_scheduler_if i1 ();
   poker_betting_round_scheduler #(.TIMEOUT_CYC(TO), .MAX_INVALID(3)) dut (
      .clk(clk), .rst_n(rst_n), .round_start(round_start), .first_player(first_player),
      .new_hand(new_hand), .stack_load(stack_load), .stack_init(stack_init),
      .p0(i0), .p1(i1), .pot_size(pot_size), .round_done(round_done),
      .hand_over(hand_over), .winner(winner)
   );
   always #5 clk = ~clk;
   // scoreboard: every round_done pops the expected settlement
   always @(negedge clk) begin
      exp_t e;
      inv1 = inv1 + int'(i1.invalid);
      req1 = req1 + int'(i1.request);
      if (round_done) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_round_done ho=%0b pot=%0d", hand_over, pot_size);
         end else begin
            e = sb.pop_front();
            if ({hand_over, winner, pot_size, i0.money_left, i1.money_left} !== e) begin
               errors++;
               $display("FAIL round_result got ho=%0b w=%0b pot=%0d s0=%0d s1=%0d exp ho=%0b w=%0b pot=%0d s0=%0d s1=%0d",
                        hand_over, winner, pot_size, i0.money_left, i1.money_left, e.ho, e.w, e.pot, e.s0, e.s1);
            end
         end
      end
   end
   function automatic logic req(input int p);
      return p == 1 ? i1.request : i0.request;
   endfunction
   function automatic logic ackd(input int p);
      return p == 1 ? i1.ack : i0.ack;
   endfunction
   function automatic logic invd(input int p);
      return p == 1 ? i1.invalid : i0.invalid;
   endfunction
   task automatic drive(input int p, input logic v, input logic [2:0] a, input money_t b);
      if (p == 1) begin
         i1.output_valid = v; i1.action = a; i1.make_bet = b;
      end else begin
         i0.output_valid = v; i0.action = a; i0.make_bet = b;
      end
   endtask
   // player bot: wait for request, offer move, report 1=accepted 0=rejected 2=no response
   task automatic move(input int p, input logic [2:0] a, input money_t b, output int res);
      int n = 0;
      while (!req(p) && n < 50) begin @(negedge clk); n++; end
      if (!req(p)) begin res = 2; return; end
      drive(p, 1'b1, a, b);
      res = 2;
      for (int k = 0; k < 50 && res == 2; k++) begin
         @(negedge clk);
         if (ackd(p)) res = 1;
         else if (invd(p)) res = 0;
      end
      drive(p, 1'b0, A_NONE, '0);
      for (int k = 0; k < 50 && ackd(p); k++) @(negedge clk);
   endtask
   task automatic do_reset();
      rst_n = 1'b0; round_start = 1'b0; new_hand = 1'b0; stack_load = 1'b0;
      drive(0, 1'b0, A_NONE, '0);
      drive(1, 1'b0, A_NONE, '0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask
   task automatic load(input money_t v);
      stack_load = 1'b1; stack_init = v;
      @(negedge clk);
      stack_load = 1'b0;
   endtask
   task automatic start(input logic fp);
      round_start = 1'b1; first_player = fp;
      @(negedge clk);
      round_start = 1'b0;
   endtask
   task automatic wait_done(input int bound);
      int n = 0;
      while (sb.size() != 0 && n < bound) begin @(negedge clk); n++; end
      if (sb.size() != 0) begin
         errors++; checks++;
         $display("FAIL round_done_timeout pending=%0d after %0d cycles", sb.size(), bound);
         sb.delete();
      end
   endtask
   task automatic expect_move(input string nm, input int p, input logic [2:0] a, input money_t b, input int want);
      int res;
      move(p, a, b, res);
      checks++;
      if (res !== want) begin errors++; $display("FAIL %s got=%0d exp=%0d", nm, res, want); end
   endtask
   task automatic test_reset();
      do_reset();
      checks++;
      if ({round_done, hand_over, winner, pot_size} !== 11'd0) begin
         errors++; $display("FAIL reset_status got=%0b%0b%0b pot=%0d exp=0", round_done, hand_over, winner, pot_size);
      end
      checks++;
      if ({i0.request, i1.request, i0.ack, i1.ack, i0.invalid, i1.invalid} !== 6'd0) begin
         errors++; $display("FAIL reset_handshake got=%b exp=0", {i0.request, i1.request, i0.ack, i1.ack, i0.invalid, i1.invalid});
      end
      checks++;
      if ({i0.money_left, i1.money_left, i0.opp_bet, i1.opp_bet, i0.opp_action, i1.opp_action} !== 38'd0) begin
         errors++; $display("FAIL reset_view got s0=%0d s1=%0d oa0=%0d oa1=%0d exp=0", i0.money_left, i1.money_left, i0.opp_action, i1.opp_action);
      end
   endtask
   task automatic test_bet_call();
      do_reset();
      load(8'd100);
      sb.push_back('{1'b0, 1'b0, 8'd20, 8'd90, 8'd90});
      start(1'b0);
      expect_move("bet_call_p0_bet", 0, A_BET, 8'd10, 1);
      expect_move("bet_call_p1_call", 1, A_CALL, 8'd0, 1);
      wait_done(20);
      checks++;
      if (i1.opp_action !== A_BET || i1.opp_bet !== 8'd10) begin
         errors++; $display("FAIL p1_view got=%0d/%0d exp=%0d/10", i1.opp_action, i1.opp_bet, A_BET);
      end
      checks++;
      if (i0.opp_action !== A_CALL || i0.opp_bet !== 8'd10) begin
         errors++; $display("FAIL p0_view got=%0d/%0d exp=%0d/10", i0.opp_action, i0.opp_bet, A_CALL);
      end
   endtask
   task automatic test_invalid();
      do_reset();
      load(8'd100);
      sb.push_back('{1'b1, 1'b0, 8'd10, 8'd90, 8'd100});
      start(1'b0);
      expect_move("inv_p0_bet", 0, A_BET, 8'd10, 1);
      inv1 = 0;
      for (int k = 0; k < 3; k++) expect_move("inv_p1_check", 1, A_CHECK, 8'd0, 0);
      wait_done(20);
      checks++;
      if (inv1 !== 3) begin errors++; $display("FAIL invalid_pulse_cycles got=%0d exp=3", inv1); end
   endtask
   task automatic test_timeout();
      do_reset();
      load(8'd100);
      sb.push_back('{1'b1, 1'b0, 8'd0, 8'd100, 8'd100});
      start(1'b0);
      expect_move("to_p0_check", 0, A_CHECK, 8'd0, 1);
      req1 = 0;
      wait_done(TO + 100);
      checks++;
      if (req1 !== TO + 1) begin errors++; $display("FAIL timeout_request_cycles got=%0d exp=%0d", req1, TO + 1); end
   endtask
   task automatic test_all_in();
      do_reset();
      load(8'd100);
      sb.push_back('{1'b1, 1'b1, 8'd40, 8'd100, 8'd60});
      start(1'b0);
      expect_move("ai_p0_check", 0, A_CHECK, 8'd0, 1);
      expect_move("ai_p1_bet", 1, A_BET, 8'd40, 1);
      expect_move("ai_p0_fold", 0, A_FOLD, 8'd0, 1);
      wait_done(20);
      new_hand = 1'b1;
      @(negedge clk);
      new_hand = 1'b0;
      sb.push_back('{1'b0, 1'b0, 8'd200, 8'd0, 8'd0});
      start(1'b0);
      expect_move("ai_p0_allin", 0, A_ALL_IN, 8'd100, 1);
      expect_move("ai_p1_call", 1, A_CALL, 8'd0, 1);
      wait_done(20);
      checks++;
      if (i0.opp_bet !== 8'd60 || i1.opp_bet !== 8'd100) begin
         errors++; $display("FAIL allin_bets got=%0d/%0d exp=60/100", i0.opp_bet, i1.opp_bet);
      end
   endtask
   task automatic test_new_hand_abort();
      int n = 0;
      do_reset();
      load(8'd100);
      start(1'b0);
      while (!i0.request && n < 20) begin @(negedge clk); n++; end
      repeat (2) @(negedge clk);
      round_start = 1'b1; first_player = 1'b1;
      @(negedge clk);
      round_start = 1'b0;
      checks++;
      if (i0.request !== 1'b1 || i1.request !== 1'b0) begin
         errors++; $display("FAIL busy_round_start got=%b%b exp=10", i0.request, i1.request);
      end
      new_hand = 1'b1;
      @(negedge clk);
      new_hand = 1'b0;
      checks++;
      if (i0.request !== 1'b0 || i0.ack !== 1'b0) begin
         errors++; $display("FAIL abort_request got=%b%b exp=00", i0.request, i0.ack);
      end
      repeat (5) @(negedge clk);
   endtask
   task automatic test_back_to_back();
      sb.push_back('{1'b0, 1'b0, 8'd0, 8'd100, 8'd100});
      start(1'b1);
      expect_move("b2b_p1_check", 1, A_CHECK, 8'd0, 1);
      expect_move("b2b_p0_check", 0, A_CHECK, 8'd0, 1);
      wait_done(20);
      checks++;
      if (i0.opp_action !== A_CHECK || i1.opp_action !== A_CHECK) begin
         errors++; $display("FAIL check_view got=%0d/%0d exp=%0d", i0.opp_action, i1.opp_action, A_CHECK);
      end
   endtask
   task automatic test_async_reset();
      int n = 0;
      start(1'b0);
      while (!i0.request && n < 20) begin @(negedge clk); n++; end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (i0.request !== 1'b0 || i0.money_left !== 8'd0) begin
         errors++; $display("FAIL async_reset got req=%b s0=%0d exp=0/0", i0.request, i0.money_left);
      end
      do_reset();
   endtask
   initial begin
      test_reset();
      test_bet_call();
      test_invalid();
      test_timeout();
      test_all_in();
      test_new_hand_abort();
      test_back_to_back();
      test_async_reset();
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
